// File: rtl/tetris_key_repeat.sv
// Frame-rate key conditioner for Tetris: decodes packed HID keycodes into held flags and
// emits single-frame move commands with edge, DAS/ARR and fixed-rate soft-drop repeat.
module tetris_key_repeat #(
    parameter int unsigned DAS_DELAY   = 10,
    parameter int unsigned ARR_PERIOD  = 3,
    parameter int unsigned SOFT_PERIOD = 2,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [31:0] keycode,
    output logic        move_left,
    output logic        move_right,
    output logic        soft_drop,
    output logic        rotate,
    output logic        hard_drop
);

    localparam logic [7:0] KeyLeft     = 8'h04;
    localparam logic [7:0] KeyRight    = 8'h07;
    localparam logic [7:0] KeySoft     = 8'h16;
    localparam logic [7:0] KeyRotate   = 8'h1A;
    localparam logic [7:0] KeyHard     = 8'h2C;
    localparam logic [7:0] KeyRollover = 8'h01;

    localparam logic [CNT_W-1:0] DasLast  = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] ArrLast  = CNT_W'(ARR_PERIOD - 1);
    localparam logic [CNT_W-1:0] SoftLast = CNT_W'(SOFT_PERIOD - 1);

    localparam logic DirL = 1'b0;
    localparam logic DirR = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StCharge,
        StRepeat
    } h_state_e;

    logic held_left, held_right, held_soft, held_rot, held_hard;
    logic prev_left_q, prev_right_q, prev_soft_q, prev_rot_q, prev_hard_q;
    logic rise_left, rise_right, rise_soft, rise_rot, rise_hard;

    h_state_e          h_state_q;
    logic              dir_q;
    logic [CNT_W-1:0]  h_cnt_q;
    logic [CNT_W-1:0]  soft_cnt_q;

    logic dir_held, opp_held, opp_rise;

    always_comb begin
        logic rollover;
        held_left  = 1'b0;
        held_right = 1'b0;
        held_soft  = 1'b0;
        held_rot   = 1'b0;
        held_hard  = 1'b0;
        rollover   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keycode[8*i +: 8] == KeyLeft)     held_left  = 1'b1;
            if (keycode[8*i +: 8] == KeyRight)    held_right = 1'b1;
            if (keycode[8*i +: 8] == KeySoft)     held_soft  = 1'b1;
            if (keycode[8*i +: 8] == KeyRotate)   held_rot   = 1'b1;
            if (keycode[8*i +: 8] == KeyHard)     held_hard  = 1'b1;
            if (keycode[8*i +: 8] == KeyRollover) rollover   = 1'b1;
        end
        // Keyboard could not report reliably this frame: treat everything as released.
        if (rollover) begin
            held_left  = 1'b0;
            held_right = 1'b0;
            held_soft  = 1'b0;
            held_rot   = 1'b0;
            held_hard  = 1'b0;
        end
    end

    assign rise_left  = held_left  & ~prev_left_q;
    assign rise_right = held_right & ~prev_right_q;
    assign rise_soft  = held_soft  & ~prev_soft_q;
    assign rise_rot   = held_rot   & ~prev_rot_q;
    assign rise_hard  = held_hard  & ~prev_hard_q;

    assign dir_held = (dir_q == DirL) ? held_left  : held_right;
    assign opp_held = (dir_q == DirL) ? held_right : held_left;
    assign opp_rise = (dir_q == DirL) ? rise_right : rise_left;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            prev_left_q  <= 1'b0;
            prev_right_q <= 1'b0;
            prev_soft_q  <= 1'b0;
            prev_rot_q   <= 1'b0;
            prev_hard_q  <= 1'b0;
            h_state_q    <= StIdle;
            dir_q        <= DirL;
            h_cnt_q      <= '0;
            soft_cnt_q   <= '0;
            move_left    <= 1'b0;
            move_right   <= 1'b0;
            soft_drop    <= 1'b0;
            rotate       <= 1'b0;
            hard_drop    <= 1'b0;
        end else begin
            prev_left_q  <= held_left;
            prev_right_q <= held_right;
            prev_soft_q  <= held_soft;
            prev_rot_q   <= held_rot;
            prev_hard_q  <= held_hard;

            rotate    <= rise_rot;
            hard_drop <= rise_hard;

            if (rise_soft) begin
                soft_drop  <= 1'b1;
                soft_cnt_q <= '0;
            end else if (held_soft) begin
                if (soft_cnt_q == SoftLast) begin
                    soft_drop  <= 1'b1;
                    soft_cnt_q <= '0;
                end else begin
                    soft_drop  <= 1'b0;
                    soft_cnt_q <= soft_cnt_q + 1'b1;
                end
            end else begin
                soft_drop  <= 1'b0;
                soft_cnt_q <= '0;
            end

            move_left  <= 1'b0;
            move_right <= 1'b0;
            unique case (h_state_q)
                StIdle: begin
                    // Left wins a same-frame double press.
                    if (rise_left) begin
                        move_left <= 1'b1;
                        dir_q     <= DirL;
                        h_cnt_q   <= '0;
                        h_state_q <= StCharge;
                    end else if (rise_right) begin
                        move_right <= 1'b1;
                        dir_q      <= DirR;
                        h_cnt_q    <= '0;
                        h_state_q  <= StCharge;
                    end
                end
                StCharge, StRepeat: begin
                    if (opp_rise) begin
                        dir_q      <= ~dir_q;
                        move_left  <= (dir_q == DirR);
                        move_right <= (dir_q == DirL);
                        h_cnt_q    <= '0;
                        h_state_q  <= StCharge;
                    end else if (!dir_held) begin
                        h_cnt_q <= '0;
                        if (opp_held) begin
                            // Fall back to the still-held key silently; it re-charges DAS.
                            dir_q     <= ~dir_q;
                            h_state_q <= StCharge;
                        end else begin
                            h_state_q <= StIdle;
                        end
                    end else if (h_state_q == StCharge) begin
                        if (h_cnt_q == DasLast) begin
                            move_left  <= (dir_q == DirL);
                            move_right <= (dir_q == DirR);
                            h_cnt_q    <= '0;
                            h_state_q  <= StRepeat;
                        end else begin
                            h_cnt_q <= h_cnt_q + 1'b1;
                        end
                    end else begin
                        if (h_cnt_q == ArrLast) begin
                            move_left  <= (dir_q == DirL);
                            move_right <= (dir_q == DirR);
                            h_cnt_q    <= '0;
                        end else begin
                            h_cnt_q <= h_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    h_state_q <= StIdle;
                    h_cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_key_repeat.sv
// Directed bench for tetris_key_repeat: a table of per-frame keycodes with hand-computed
// pulse patterns, plus hand-written async-reset sequences.
module tb_tetris_key_repeat;

    // Expected output bit order: {move_left, move_right, soft_drop, rotate, hard_drop}
    localparam logic [4:0] L = 5'b10000;
    localparam logic [4:0] R = 5'b01000;
    localparam logic [4:0] S = 5'b00100;
    localparam logic [4:0] W = 5'b00010;
    localparam logic [4:0] H = 5'b00001;
    localparam logic [4:0] N = 5'b00000;

    typedef struct {
        string       name;
        logic [31:0] kc;
        logic [4:0]  exp;
    } vec_t;

    logic        frame_clk;
    logic        Reset;
    logic [31:0] keycode;
    logic        move_left, move_right, soft_drop, rotate, hard_drop;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    tetris_key_repeat dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .move_left  (move_left),
        .move_right (move_right),
        .soft_drop  (soft_drop),
        .rotate     (rotate),
        .hard_drop  (hard_drop)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    function automatic logic [4:0] outs();
        return {move_left, move_right, soft_drop, rotate, hard_drop};
    endfunction

    task automatic check(input string name, input int idx, input logic [4:0] exp);
        n_cmp++;
        if (outs() !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %b, expected %b (L R S W H)", name, idx, outs(), exp);
        end
    endtask

    task automatic add(input string name, input logic [31:0] kc, input logic [4:0] exp);
        vec_t v;
        v.name = name;
        v.kc   = kc;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic step(input string name, input int idx, input logic [31:0] kc,
                        input logic [4:0] exp);
        keycode = kc;
        @(posedge frame_clk);
        #1;
        check(name, idx, exp);
    endtask

    initial begin
        // Left hold: pulses at 0, 10, 13, 16, 19
        for (int i = 0; i < 20; i++)
            add("left_hold", 32'h0000_0004,
                (i == 0 || i == 10 || i == 13 || i == 16 || i == 19) ? L : N);
        add("left_release", 32'h0, N);

        // Rotate: one pulse per press, no repeat
        for (int i = 0; i < 5; i++) add("rot_hold", 32'h0000_001A, (i == 0) ? W : N);
        add("rot_release", 32'h0, N);
        add("rot_byte3", 32'h1A00_0000, W);
        add("rot_byte3_hold", 32'h1A00_0000, N);
        add("rot_release2", 32'h0, N);

        // Left/right interplay
        for (int i = 0; i < 4; i++) add("lr_a", 32'h0000_0004, (i == 0) ? L : N);
        for (int i = 4; i < 16; i++)
            add("lr_ad", 32'h0000_0704, (i == 4 || i == 14) ? R : N);
        for (int i = 16; i < 27; i++) add("lr_a_again", 32'h0000_0004, (i == 26) ? L : N);
        add("lr_release", 32'h0, N);

        // Soft drop with rollover
        for (int i = 0; i < 7; i++) add("soft_hold", 32'h0000_0016, (i % 2 == 0) ? S : N);
        add("soft_rollover", 32'h0000_0116, N);
        add("soft_return", 32'h0000_0016, S);
        add("soft_return2", 32'h0000_0016, N);
        add("soft_release", 32'h0, N);
        add("soft_repress", 32'h0000_0016, S);
        add("soft_release2", 32'h0, N);

        // Rollover hides rises of every key
        add("rollover_all", 32'h0104_1A2C, N);
        add("rollover_clear", 32'h0, N);

        // Same-frame presses
        add("ad_together", 32'h0000_0704, L);
        add("ad_hold", 32'h0000_0704, N);
        add("ad_release", 32'h0, N);
        add("space_w", 32'h0000_2C1A, H | W);
        add("space_w_hold", 32'h0000_2C1A, N);
        add("space_w_release", 32'h0, N);

        // Single-frame tap then idle, then fresh press pulses again
        add("tap", 32'h0000_0007, R);
        for (int i = 0; i < 12; i++) add("tap_idle", 32'h0, N);
        add("tap_repress", 32'h0000_0004, L);
        add("tap_release", 32'h0, N);

        Reset   = 1'b1;
        keycode = 32'h0;
        #12;
        check("reset_state", 0, N);
        #5 Reset = 1'b0;

        foreach (vecs[i]) step(vecs[i].name, i, vecs[i].kc, vecs[i].exp);

        // Reset mid-operation: hold A into REPEAT, reset while move_left is high
        for (int i = 0; i < 11; i++)
            step("pre_reset", i, 32'h0000_0004, (i == 0 || i == 10) ? L : N);
        #2 Reset = 1'b1;
        #1 check("async_reset", 0, N);
        @(posedge frame_clk);
        #1 check("reset_held", 0, N);
        #2 Reset = 1'b0;
        for (int i = 0; i < 14; i++)
            step("post_reset", i, 32'h0000_0004, (i == 0 || i == 10 || i == 13) ? L : N);
        step("post_reset_release", 0, 32'h0, N);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
